// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array result path.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int unsigned PSUM_WIDTH_DEF = 16;
    localparam int unsigned NUM_OUT_DEF    = 14;

endpackage

// File: rtl/psum_ram.sv
// Simple dual-port result RAM: one write port, one synchronous read-first read port.
module psum_ram #(
    parameter int unsigned PSUM_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [PSUM_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [PSUM_WIDTH-1:0] rd_data
);

    logic [PSUM_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register kept apart from the array so the reset only touches rd_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/psum_bram_writer.sv
// Packs the systolic array's psum stream into a result RAM and flags completion.
// Optional `define PSUM_RELU_EN clamps negative psums to zero on the write path.
module psum_bram_writer
    import sa_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_OUT    = NUM_OUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  valid_in,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [PSUM_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    if (NUM_OUT < 1 || NUM_OUT > (1 << ADDR_WIDTH)) begin : g_num_out_check
        $error("psum_bram_writer: NUM_OUT must be in 1..2**ADDR_WIDTH");
    end

    localparam logic [ADDR_WIDTH:0] NUM_OUT_C = (ADDR_WIDTH+1)'(NUM_OUT);

    state_t                state;
    logic                  we;
    logic [PSUM_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH:0]   wr_next;

    assign we      = (state == CAPTURE) && valid_in && !start;
    assign wr_next = wr_count + {{ADDR_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        wr_data = psum_in;
`ifdef PSUM_RELU_EN
        if (psum_in[PSUM_WIDTH-1]) begin
            wr_data = '0;
        end
`endif
    end

    // start wins over valid_in in every state: the beat is dropped and overflow cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_count <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (start) begin
                state    <= CAPTURE;
                wr_count <= '0;
                busy     <= 1'b1;
                done     <= 1'b0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    CAPTURE: begin
                        if (valid_in) begin
                            wr_count <= wr_next;
                            if (wr_next == NUM_OUT_C) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    IDLE, DONE: begin
                        if (valid_in) begin
                            overflow <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    psum_ram #(
        .PSUM_WIDTH (PSUM_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wr_addr (wr_count[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
